// File: rtl/pic_pkg.sv
// Shared definitions for the PIC slice: acknowledge sequencer state
// encoding, default pulse/gap timing and the interrupt vector width.
package pic_pkg;

    localparam int unsigned PULSE_CYC_DEF = 4;
    localparam int unsigned GAP_CYC_DEF   = 2;
    localparam int unsigned VEC_W         = 8;
    localparam int unsigned CNT_W         = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        P1      = 3'd1,
        GAP     = 3'd2,
        P2      = 3'd3,
        HOLD    = 3'd4,
        RECOVER = 3'd5
    } pic_state_e;

endpackage

// File: rtl/pic_sync2.sv
// Generic two-flop synchroniser with synchronous active-low reset.
// Ports:
//   clk   - destination clock
//   reset - synchronous active-low reset, clears both flops
//   d     - asynchronous input bus (bits are synchronised independently)
//   q     - synchronised output, two clocks of latency
module pic_sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (!reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pic_inta_ctrl.sv
// CPU-side interrupt-acknowledge sequencer. Synchronises the PIC's INT,
// and when the CPU has interrupts enabled issues the two-pulse NINTA
// sequence, captures the vector byte on D during the second pulse and
// hands it to the CPU core over a valid/ack handshake.
// Ports:
//   clk       - system clock
//   reset     - synchronous active-low reset
//   INT       - interrupt request from the PIC (asynchronous)
//   D         - PIC data bus, sampled at the end of the second pulse
//   if_en     - CPU interrupt-enable flag
//   vec_ack   - CPU core has consumed the vector
//   NINTA     - active-low interrupt acknowledge to the PIC (registered)
//   vec       - captured interrupt vector
//   vec_valid - vec holds a new, unconsumed vector
//   busy      - sequencer is not idle
module pic_inta_ctrl
    import pic_pkg::*;
#(
    parameter int unsigned PULSE_CYC = PULSE_CYC_DEF,
    parameter int unsigned GAP_CYC   = GAP_CYC_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             INT,
    input  logic [VEC_W-1:0] D,
    input  logic             if_en,
    input  logic             vec_ack,
    output logic             NINTA,
    output logic [VEC_W-1:0] vec,
    output logic             vec_valid,
    output logic             busy
);

    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYC - 1);

    logic             int_s;
    pic_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [VEC_W-1:0] vec_nxt;
    logic             valid_nxt;
    logic             ninta_nxt;

    pic_sync2 #(.WIDTH(1)) u_int_sync (
        .clk   (clk),
        .reset (reset),
        .d     (INT),
        .q     (int_s)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        vec_nxt   = vec;
        valid_nxt = vec_valid;
        case (state)
            IDLE: begin
                if (int_s && if_en && !vec_valid) begin
                    state_nxt = P1;
                    cnt_nxt   = PULSE_LD;
                end
            end
            P1: begin
                if (cnt == '0) begin
                    state_nxt = GAP;
                    cnt_nxt   = GAP_LD;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    state_nxt = P2;
                    cnt_nxt   = PULSE_LD;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            P2: begin
                // D is sampled on the last low cycle, while the PIC still drives it.
                if (cnt == '0) begin
                    state_nxt = HOLD;
                    vec_nxt   = D;
                    valid_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            HOLD: begin
                if (vec_ack) begin
                    state_nxt = RECOVER;
                    valid_nxt = 1'b0;
                    cnt_nxt   = GAP_LD;
                end
            end
            RECOVER: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Registering the decode of the next state keeps NINTA glitch-free and
    // aligned with the state-entry edges.
    assign ninta_nxt = !((state_nxt == P1) || (state_nxt == P2));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            vec       <= '0;
            vec_valid <= 1'b0;
            NINTA     <= 1'b1;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            vec       <= vec_nxt;
            vec_valid <= valid_nxt;
            NINTA     <= ninta_nxt;
        end
    end

    assign busy = (state != IDLE);

endmodule
